regfile_wb_buffer: RTL



---
 rtl/regfile_wb_buffer_if.sv | 37 +++
 rtl/regfile_wb_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/regfile_wb_buffer_if.sv
// Producer/decode-side bundle of the writeback buffer: push, hold and read addresses in;
// write port, forwarding and FIFO status out.
interface regfile_wb_buffer_if #(
  parameter int CW = 3
);
  logic          Input_push;
  logic [4:0]    Input_dest;
  logic [31:0]   Input_data;
  logic          Input_hold;
  logic [4:0]    Input_RA1;
  logic [4:0]    Input_RA2;
  logic          monitor_WE;
  logic [4:0]    monitor_WA;
  logic [31:0]   monitor_WD;
  logic          monitor_hit1;
  logic          monitor_hit2;
  logic [31:0]   monitor_fwd1;
  logic [31:0]   monitor_fwd2;
  logic          monitor_full;
  logic          monitor_empty;
  logic [CW-1:0] monitor_count;
  logic          monitor_overflow;

  modport master (
    output Input_push, Input_dest, Input_data, Input_hold, Input_RA1, Input_RA2,
    input  monitor_WE, monitor_WA, monitor_WD, monitor_hit1, monitor_hit2,
    input  monitor_fwd1, monitor_fwd2, monitor_full, monitor_empty, monitor_count,
    input  monitor_overflow
  );

  modport slave (
    input  Input_push, Input_dest, Input_data, Input_hold, Input_RA1, Input_RA2,
    output monitor_WE, monitor_WA, monitor_WD, monitor_hit1, monitor_hit2,
    output monitor_fwd1, monitor_fwd2, monitor_full, monitor_empty, monitor_count,
    output monitor_overflow
  );
endinterface

// File: rtl/regfile_wb_buffer.sv
// In-order writeback FIFO owning the regfile write port, with read-address forwarding; push-to-write 1 cycle.
// Backpressure: hold stalls the drain; pushes into a full buffer without a same-cycle pop are dropped (sticky overflow).
module regfile_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic                Input_clk,
  input logic                Input_rst,
  regfile_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push_nz;
  logic          accept;
  logic          drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = !empty && !bus.Input_hold && !Input_rst;
  assign push_nz = bus.Input_push && (bus.Input_dest != 5'd0);
  // A full buffer can still take a push when its head leaves on the same edge.
  assign accept  = push_nz && (!full || pop);
  assign drop    = push_nz && !accept;

  always_ff @(posedge Input_clk) begin
    if (Input_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) tail_q <= tail_q + 1'b1;
      if (pop)    head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(accept) - CW'(pop);
      ovf_q   <= ovf_q | drop;
    end
  end

  always_ff @(posedge Input_clk) begin
    if (accept && !Input_rst) begin
      dest_q[tail_q] <= bus.Input_dest;
      data_q[tail_q] <= bus.Input_data;
    end
  end

  assign bus.monitor_WE       = pop;
  assign bus.monitor_WA       = (empty || Input_rst) ? 5'd0  : dest_q[head_q];
  assign bus.monitor_WD       = (empty || Input_rst) ? 32'd0 : data_q[head_q];
  assign bus.monitor_full     = full && !Input_rst;
  assign bus.monitor_empty    = empty || Input_rst;
  assign bus.monitor_count    = Input_rst ? '0 : count_q;
  assign bus.monitor_overflow = ovf_q && !Input_rst;

  logic [PW-1:0] slot;
  logic          hit1;
  logic          hit2;
  logic [31:0]   fwd1;
  logic [31:0]   fwd2;

  // Walk entries oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    slot = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = 32'd0;
    fwd2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (bus.Input_RA1 != 5'd0 && dest_q[slot] == bus.Input_RA1) begin
          hit1 = 1'b1;
          fwd1 = data_q[slot];
        end
        if (bus.Input_RA2 != 5'd0 && dest_q[slot] == bus.Input_RA2) begin
          hit2 = 1'b1;
          fwd2 = data_q[slot];
        end
      end
    end
    if (Input_rst) begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      fwd1 = 32'd0;
      fwd2 = 32'd0;
    end
  end

  assign bus.monitor_hit1 = hit1;
  assign bus.monitor_hit2 = hit2;
  assign bus.monitor_fwd1 = fwd1;
  assign bus.monitor_fwd2 = fwd2;
endmodule
